// File: rtl/regfile_renamed.sv
// regfile_renamed: architectural register file with per-register busy bit
// and ROB tag for an out-of-order core.
//
// Dispatch marks a destination busy with its ROB tag. Commit always writes
// the data, but releases busy/tag only when the committing tag still owns
// the register. A flush drops all rename state while keeping committed data.
// Register 0 is hardwired to zero and never becomes busy.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : a read of the register being committed this cycle returns
//               the commit data, with busy/tag showing the release if the
//               commit owns the register.
//   undefined : reads show stored state only; a commit is visible next cycle.
module regfile_renamed #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int TAG_W = 4,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [NRD-1:0]        rd_busy,
  output logic [NRD*TAG_W-1:0]  rd_tag,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_addr,
  input  logic [TAG_W-1:0]      iss_tag,
  input  logic                  cmt_en,
  input  logic [AW-1:0]         cmt_addr,
  input  logic [TAG_W-1:0]      cmt_tag,
  input  logic [XLEN-1:0]       cmt_data,
  input  logic                  flush
);

  logic [XLEN-1:0]  data_q [NREG];
  logic [TAG_W-1:0] tag_q  [NREG];
  logic [NREG-1:0]  busy_q;

  // Register state update: commit data, then issue/flush/commit ownership.
  // Issue is checked before the commit release so a same-cycle issue to the
  // committed register keeps ownership for the new writer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      for (int i = 0; i < NREG; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (cmt_en && (cmt_addr == AW'(i))) begin
          data_q[i] <= cmt_data;
        end
        if (flush) begin
          busy_q[i] <= 1'b0;
          tag_q[i]  <= '0;
        end else if (iss_en && (iss_addr == AW'(i))) begin
          busy_q[i] <= 1'b1;
          tag_q[i]  <= iss_tag;
        end else if (cmt_en && (cmt_addr == AW'(i)) &&
                     busy_q[i] && (tag_q[i] == cmt_tag)) begin
          busy_q[i] <= 1'b0;
          tag_q[i]  <= '0;
        end
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]    addr;
    logic [XLEN-1:0]  port_data;
    logic             port_busy;
    logic [TAG_W-1:0] port_tag;

    assign addr = rd_addr[k*AW +: AW];

    // Combinational read of one port; register 0 and reset force zeros.
    always_comb begin
      port_data = '0;
      port_busy = 1'b0;
      port_tag  = '0;
      if (!rst && (addr != '0)) begin
        port_data = data_q[addr];
        port_busy = busy_q[addr];
        port_tag  = tag_q[addr];
`ifdef REGFILE_BYPASS_EN
        if (cmt_en && (cmt_addr == addr)) begin
          port_data = cmt_data;
          if (busy_q[addr] && (tag_q[addr] == cmt_tag)) begin
            port_busy = 1'b0;
            port_tag  = '0;
          end
        end
`endif
      end
    end

    assign rd_data[k*XLEN +: XLEN]   = port_data;
    assign rd_busy[k]                = port_busy;
    assign rd_tag[k*TAG_W +: TAG_W]  = port_tag;
  end

endmodule

// File: tb/tb_regfile_renamed.sv
// tb_regfile_renamed: directed and randomized checks of regfile_renamed
// against a behavioural register-file model kept in the bench.
module tb_regfile_renamed;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int TAG_W = 4;
  localparam int NRD   = 2;
  localparam int AW    = $clog2(NREG);

  logic                 clk;
  logic                 rst;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic [NRD*TAG_W-1:0] rd_tag;
  logic                 iss_en;
  logic [AW-1:0]        iss_addr;
  logic [TAG_W-1:0]     iss_tag;
  logic                 cmt_en;
  logic [AW-1:0]        cmt_addr;
  logic [TAG_W-1:0]     cmt_tag;
  logic [XLEN-1:0]      cmt_data;
  logic                 flush;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0]  m_data [NREG];
  logic             m_busy [NREG];
  logic [TAG_W-1:0] m_tag  [NREG];

  regfile_renamed #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NRD(NRD)) dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .rd_tag(rd_tag),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_tag(iss_tag),
    .cmt_en(cmt_en), .cmt_addr(cmt_addr), .cmt_tag(cmt_tag),
    .cmt_data(cmt_data), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: asynchronous reset wipes everything
  always @(posedge rst) begin
    for (int i = 0; i < NREG; i++) begin
      m_data[i] = '0;
      m_busy[i] = 1'b0;
      m_tag[i]  = '0;
    end
  end

  // Model: per-edge architectural update from the operation rules
  always @(posedge clk) begin
    if (!rst) begin
      logic owned;
      owned = 1'b0;
      if (cmt_en && cmt_addr != 0) begin
        owned = m_busy[cmt_addr] && (m_tag[cmt_addr] == cmt_tag);
        m_data[cmt_addr] = cmt_data;
      end
      if (flush) begin
        for (int i = 0; i < NREG; i++) begin
          m_busy[i] = 1'b0;
          m_tag[i]  = '0;
        end
      end else begin
        if (owned) begin
          m_busy[cmt_addr] = 1'b0;
          m_tag[cmt_addr]  = '0;
        end
        if (iss_en && iss_addr != 0) begin
          m_busy[iss_addr] = 1'b1;
          m_tag[iss_addr]  = iss_tag;
        end
      end
    end
  end

  // Model: what a read port must show right now
  function automatic void modelRead(input logic [AW-1:0] a,
                                    output logic [XLEN-1:0] d,
                                    output logic b,
                                    output logic [TAG_W-1:0] t);
    d = '0; b = 1'b0; t = '0;
    if (!rst && a != 0) begin
      d = m_data[a]; b = m_busy[a]; t = m_tag[a];
`ifdef REGFILE_BYPASS_EN
      if (cmt_en && cmt_addr == a) begin
        d = cmt_data;
        if (m_busy[a] && m_tag[a] == cmt_tag) begin
          b = 1'b0; t = '0;
        end
      end
`endif
    end
  endfunction

  // Continuous compare of every read port against the model
  always @(negedge clk) begin
    for (int k = 0; k < NRD; k++) begin
      logic [XLEN-1:0]  ed;
      logic             eb;
      logic [TAG_W-1:0] et;
      modelRead(rd_addr[k*AW +: AW], ed, eb, et);
      checks++;
      if (rd_data[k*XLEN +: XLEN] !== ed || rd_busy[k] !== eb ||
          rd_tag[k*TAG_W +: TAG_W] !== et) begin
        errors++;
        $display("[TB] FAIL model_port%0d addr=%0d at %0t: got data=%h busy=%b tag=%h, expected data=%h busy=%b tag=%h",
                 k, rd_addr[k*AW +: AW], $time, rd_data[k*XLEN +: XLEN], rd_busy[k],
                 rd_tag[k*TAG_W +: TAG_W], ed, eb, et);
      end
    end
  end

  task automatic applyStimulus(input logic ie, input logic [AW-1:0] ia,
                               input logic [TAG_W-1:0] it, input logic ce,
                               input logic [AW-1:0] ca, input logic [TAG_W-1:0] ct,
                               input logic [XLEN-1:0] cd, input logic fl);
    @(posedge clk);
    #1;
    iss_en = ie; iss_addr = ia; iss_tag = it;
    cmt_en = ce; cmt_addr = ca; cmt_tag = ct; cmt_data = cd;
    flush = fl;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic setRead(input int a0, input int a1);
    rd_addr[0*AW +: AW] = AW'(a0);
    rd_addr[1*AW +: AW] = AW'(a1);
  endtask

  task automatic checkOutput(input string name, input int port,
                             input logic [XLEN-1:0] ed, input logic eb,
                             input logic [TAG_W-1:0] et);
    #1;
    checks++;
    if (rd_data[port*XLEN +: XLEN] !== ed || rd_busy[port] !== eb ||
        rd_tag[port*TAG_W +: TAG_W] !== et) begin
      errors++;
      $display("[TB] FAIL %s: port%0d got data=%h busy=%b tag=%h, expected data=%h busy=%b tag=%h",
               name, port, rd_data[port*XLEN +: XLEN], rd_busy[port],
               rd_tag[port*TAG_W +: TAG_W], ed, eb, et);
    end
  endtask

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    iss_en = 1'b0; iss_addr = '0; iss_tag = '0;
    cmt_en = 1'b0; cmt_addr = '0; cmt_tag = '0; cmt_data = '0;
    flush = 1'b0;
    setRead(5, 0);
    #2;
    checkOutput("reset_x5", 0, 32'h0, 1'b0, 4'h0);
    #9 rst = 1'b0;

    $display("[TB] issue/commit with matching tag");
    applyStimulus(1'b1, 5'd5, 4'd3, 1'b0, '0, '0, '0, 1'b0);
    idle();
    checkOutput("issue_busy", 0, 32'h0, 1'b1, 4'd3);
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd5, 4'd3, 32'hDEADBEEF, 1'b0);
`ifdef REGFILE_BYPASS_EN
    checkOutput("commit_same_cycle", 0, 32'hDEADBEEF, 1'b0, 4'd0);
`else
    checkOutput("commit_same_cycle", 0, 32'h0, 1'b1, 4'd3);
`endif
    idle();
    checkOutput("commit_done", 0, 32'hDEADBEEF, 1'b0, 4'd0);

    $display("[TB] stale commit keeps younger owner");
    setRead(0, 7);
    applyStimulus(1'b1, 5'd7, 4'd2, 1'b0, '0, '0, '0, 1'b0);
    applyStimulus(1'b1, 5'd7, 4'd9, 1'b0, '0, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd7, 4'd2, 32'h11, 1'b0);
    idle();
    checkOutput("stale_commit", 1, 32'h11, 1'b1, 4'd9);

    $display("[TB] simultaneous issue/commit, then flush");
    setRead(4, 7);
    applyStimulus(1'b1, 5'd4, 4'd1, 1'b0, '0, '0, '0, 1'b0);
    applyStimulus(1'b1, 5'd4, 4'd6, 1'b1, 5'd4, 4'd1, 32'h22, 1'b0);
    idle();
    checkOutput("simul_issue_wins", 0, 32'h22, 1'b1, 4'd6);
    applyStimulus(1'b1, 5'd8, 4'd3, 1'b0, '0, '0, '0, 1'b1);
    idle();
    setRead(8, 7);
    checkOutput("flush_drops_issue", 0, 32'h0, 1'b0, 4'd0);
    checkOutput("flush_clears_x7", 1, 32'h11, 1'b0, 4'd0);
    setRead(4, 7);
    checkOutput("flush_clears_x4", 0, 32'h22, 1'b0, 4'd0);

    $display("[TB] register 0 is hardwired");
    applyStimulus(1'b1, 5'd0, 4'd5, 1'b1, 5'd0, 4'd5, 32'hFFFFFFFF, 1'b0);
    setRead(0, 0);
    checkOutput("x0_same_cycle", 1, 32'h0, 1'b0, 4'd0);
    idle();
    checkOutput("x0_port0", 0, 32'h0, 1'b0, 4'd0);
    checkOutput("x0_port1", 1, 32'h0, 1'b0, 4'd0);

    $display("[TB] commit bypass behaviour");
    setRead(0, 3);
    applyStimulus(1'b1, 5'd3, 4'd4, 1'b0, '0, '0, '0, 1'b0);
    idle();
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd3, 4'd4, 32'hA5A5A5A5, 1'b0);
`ifdef REGFILE_BYPASS_EN
    checkOutput("bypass_same_cycle", 1, 32'hA5A5A5A5, 1'b0, 4'd0);
`else
    checkOutput("bypass_same_cycle", 1, 32'h0, 1'b1, 4'd4);
`endif
    idle();
    checkOutput("bypass_next_cycle", 1, 32'hA5A5A5A5, 1'b0, 4'd0);

    $display("[TB] asynchronous reset mid-run");
    setRead(5, 7);
    applyStimulus(1'b1, 5'd9, 4'd1, 1'b0, '0, '0, '0, 1'b0);
    #1 rst = 1'b1;
    checkOutput("midrst_port0", 0, 32'h0, 1'b0, 4'd0);
    checkOutput("midrst_port1", 1, 32'h0, 1'b0, 4'd0);
    @(negedge clk);
    iss_en = 1'b0;
    #3 rst = 1'b0;
    idle();
    checkOutput("after_rst_x5", 0, 32'h0, 1'b0, 4'd0);
    checkOutput("after_rst_x7", 1, 32'h0, 1'b0, 4'd0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 3000; n++) begin
      logic [AW-1:0]    ia, ca;
      logic [TAG_W-1:0] ct;
      ia = AW'($urandom_range(0, 7));
      ca = AW'($urandom_range(0, 7));
      ct = ($urandom_range(0, 1) == 1) ? m_tag[ca] : TAG_W'($urandom);
      applyStimulus($urandom_range(0, 2) != 0, ia, TAG_W'($urandom),
                    $urandom_range(0, 1) == 1, ca, ct, $urandom,
                    $urandom_range(0, 24) == 0);
      setRead($urandom_range(0, 7), $urandom_range(0, 7));
      if (n == 1500) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #3 rst = 1'b0;
      end
    end

    idle();
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
